// File: rtl/exponent_bit_streamer.sv
`default_nettype none
// ==== exponent_bit_streamer : loads exponent blocks (LSB block first), emits bits MSB-first per consume ====
// ==== Optional EXP_DOUBLE_BUFFER_EN adds a second bank filled while the first streams.  Rev 1.0 ==========
module exponent_bit_streamer #(
  parameter int REGISTER_SIZE = 32,
  parameter int BITS_IN_N     = 2048
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         valid_in,
  input  logic [REGISTER_SIZE-1:0]     data_in,
  output logic                         ready_out,
  input  logic                         consumed_n_in,
  output logic                         n_bit_out,
  output logic                         n_valid_out,
  output logic                         done_out,
  output logic [$clog2(BITS_IN_N):0]   bits_remaining_out
);
  localparam int NUM_BLOCKS = BITS_IN_N / REGISTER_SIZE;
  localparam int IDX_W      = $clog2(BITS_IN_N);
  localparam int LOAD_W     = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam logic [IDX_W-1:0]  MSB_IDX    = IDX_W'(BITS_IN_N - 1);
  localparam logic [IDX_W:0]    FULL_COUNT = (IDX_W + 1)'(BITS_IN_N);
  localparam logic [LOAD_W-1:0] LAST_BLOCK = LOAD_W'(NUM_BLOCKS - 1);

  typedef enum logic [0:0] {LOADING = 1'b0, STREAMING = 1'b1} state_t;
  state_t state, state_next;

  logic [LOAD_W-1:0]    load_idx;
  logic [IDX_W-1:0]     bit_idx;
  logic [IDX_W-1:0]     wr_base;
  logic [BITS_IN_N-1:0] bank0;
  logic [BITS_IN_N-1:0] active_bits;
  logic accept, accept_last, consume, final_consume, swap, new_msb;

  assign accept        = valid_in && ready_out;
  assign accept_last   = accept && (load_idx == LAST_BLOCK);
  assign consume       = consumed_n_in && (state == STREAMING);
  assign final_consume = consume && (bit_idx == '0);
  assign wr_base       = IDX_W'(load_idx * REGISTER_SIZE);

`ifdef EXP_DOUBLE_BUFFER_EN
  logic [BITS_IN_N-1:0] bank1;
  logic [BITS_IN_N-1:0] spare_bits;
  logic active_sel, spare_full;

  assign active_bits = active_sel ? bank1 : bank0;
  assign spare_bits  = active_sel ? bank0 : bank1;
  assign ready_out   = !spare_full;
  // A swap happens whenever a full spare bank meets an idle or just-finished active bank.
  assign swap    = (spare_full || accept_last) && ((state == LOADING) || final_consume);
  assign new_msb = spare_full ? spare_bits[BITS_IN_N-1] : data_in[REGISTER_SIZE-1];

  always_ff @(posedge clk_in) begin
    if (accept) begin
      if (active_sel) bank0[wr_base +: REGISTER_SIZE] <= data_in;
      else            bank1[wr_base +: REGISTER_SIZE] <= data_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      active_sel <= 1'b0;
      spare_full <= 1'b0;
    end else if (swap) begin
      active_sel <= ~active_sel;
      spare_full <= 1'b0;
    end else if (accept_last) begin
      spare_full <= 1'b1;
    end
  end
`else
  assign active_bits = bank0;
  assign ready_out   = (state == LOADING);
  assign swap        = accept_last;
  // The MSB lives in the last block, which is being written on this very edge.
  assign new_msb     = data_in[REGISTER_SIZE-1];

  always_ff @(posedge clk_in) begin
    if (accept) bank0[wr_base +: REGISTER_SIZE] <= data_in;
  end
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= LOADING;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (swap)               state_next = STREAMING;
    else if (final_consume) state_next = LOADING;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      load_idx           <= '0;
      bit_idx            <= MSB_IDX;
      n_bit_out          <= 1'b0;
      n_valid_out        <= 1'b0;
      done_out           <= 1'b0;
      bits_remaining_out <= '0;
    end else begin
      done_out <= 1'b0;
      if (accept) load_idx <= accept_last ? '0 : load_idx + 1'b1;
      if (swap) begin
        bit_idx            <= MSB_IDX;
        bits_remaining_out <= FULL_COUNT;
        n_bit_out          <= new_msb;
        n_valid_out        <= 1'b1;
        done_out           <= final_consume;
      end else if (final_consume) begin
        bit_idx            <= MSB_IDX;
        bits_remaining_out <= '0;
        n_bit_out          <= 1'b0;
        n_valid_out        <= 1'b0;
        done_out           <= 1'b1;
      end else if (consume) begin
        bit_idx            <= bit_idx - 1'b1;
        bits_remaining_out <= bits_remaining_out - 1'b1;
        n_bit_out          <= active_bits[bit_idx - 1'b1];
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_exponent_bit_streamer.sv
`default_nettype none
// ==== tb_exponent_bit_streamer : random-gap streaming against an MSB-first exponent model. Rev 1.0 ====
module tb_exponent_bit_streamer;
  localparam int RS = 32;
  localparam int NB = 64;

  logic          clk = 1'b0;
  logic          rst_in = 1'b1;
  logic          valid_in = 1'b0;
  logic [RS-1:0] data_in = '0;
  logic          consumed_n_in = 1'b0;
  logic          ready_out, n_bit_out, n_valid_out, done_out;
  logic [6:0]    bits_remaining_out;
  int total = 0;
  int bad   = 0;

  exponent_bit_streamer #(.REGISTER_SIZE(RS), .BITS_IN_N(NB)) dut (
    .clk_in(clk), .rst_in(rst_in), .valid_in(valid_in), .data_in(data_in),
    .ready_out(ready_out), .consumed_n_in(consumed_n_in), .n_bit_out(n_bit_out),
    .n_valid_out(n_valid_out), .done_out(done_out), .bits_remaining_out(bits_remaining_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic reset_dut();
    valid_in = 1'b0; consumed_n_in = 1'b0; rst_in = 1'b1;
    @(negedge clk);
    rst_in = 1'b0;
    check("rst_ready", ready_out, 1);
    check("rst_n_valid", n_valid_out, 0);
    check("rst_n_bit", n_bit_out, 0);
    check("rst_done", done_out, 0);
    check("rst_remaining", bits_remaining_out, 0);
  endtask

  // Called on a negedge; returns on the negedge after the last handshake.
  task automatic load_exponent(input logic [63:0] e, input bit cons);
    int guard;
    consumed_n_in = cons;
    for (int b = 0; b < NB / RS; b++) begin
      valid_in = 1'b1;
      data_in  = e[b*RS +: RS];
      guard = 0;
      while (!ready_out && guard < 200) begin @(negedge clk); guard++; end
      if (guard >= 200) check("load_timeout", 0, 1);
      @(negedge clk);
    end
    valid_in = 1'b0;
    consumed_n_in = 1'b0;
  endtask

  // Reference: consume number k must see exponent bit NB-1-k, with NB-k bits left.
  task automatic stream_bits(input logic [63:0] e, input int n, input int max_gap, input bit junk);
    int gap;
    for (int k = 0; k < n; k++) begin
      check("n_valid", n_valid_out, 1);
      check("n_bit", n_bit_out, e[NB-1-k]);
      check("remaining", bits_remaining_out, NB - k);
      if (junk) begin valid_in = 1'b1; data_in = '1; end
      gap = $urandom_range(max_gap, 0);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        check("n_bit_hold", n_bit_out, e[NB-1-k]);
        if (junk) check("ready_busy", ready_out, 0);
      end
      consumed_n_in = 1'b1;
      @(negedge clk);
      consumed_n_in = 1'b0;
    end
    valid_in = 1'b0;
  endtask

  task automatic end_checks();
    check("done_pulse", done_out, 1);
    check("end_n_valid", n_valid_out, 0);
    check("end_remaining", bits_remaining_out, 0);
    check("end_ready", ready_out, 1);
    @(negedge clk);
    check("done_clear", done_out, 0);
  endtask

  initial begin
    logic [63:0] e;
    @(negedge clk);
    reset_dut();

    // consumes while idle must not disturb the load
    consumed_n_in = 1'b1;
    repeat (3) @(negedge clk);
    e = 64'h80000000_00000001;
    load_exponent(e, 1'b1);
    stream_bits(e, NB, 3, 1'b0);
    end_checks();

    e = 64'h55555555_AAAAAAAA;
    load_exponent(e, 1'b0);
    stream_bits(e, NB, 0, 1'b0);
    end_checks();

    for (int r = 0; r < 3; r++) begin
      e = {$urandom, $urandom};
      load_exponent(e, 1'b0);
      stream_bits(e, NB, 7, 1'b0);
      end_checks();
    end

`ifndef EXP_DOUBLE_BUFFER_EN
    e = {$urandom, $urandom};
    load_exponent(e, 1'b0);
    stream_bits(e, NB, 2, 1'b1);
    end_checks();
    e = {$urandom, $urandom};
    load_exponent(e, 1'b0);
    stream_bits(e, NB, 1, 1'b0);
    end_checks();
`endif

    // reset after one block, then after 10 bits
    valid_in = 1'b1; data_in = 32'hDEADBEEF;
    @(negedge clk);
    valid_in = 1'b0;
    reset_dut();
    e = {$urandom, $urandom};
    load_exponent(e, 1'b0);
    stream_bits(e, 10, 2, 1'b0);
    reset_dut();
    e = {$urandom, $urandom};
    load_exponent(e, 1'b0);
    stream_bits(e, NB, 2, 1'b0);
    end_checks();

`ifdef EXP_DOUBLE_BUFFER_EN
    load_exponent(64'h00000000_00000001, 1'b0);
    load_exponent(64'h80000000_00000000, 1'b0);
    check("db_spare_full", ready_out, 0);
    stream_bits(64'h00000000_00000001, NB, 1, 1'b0);
    check("db_done", done_out, 1);
    check("db_n_valid", n_valid_out, 1);
    check("db_msb", n_bit_out, 1);
    check("db_remaining", bits_remaining_out, NB);
    check("db_ready", ready_out, 1);
    @(negedge clk);
    check("db_done_clear", done_out, 0);
    stream_bits(64'h80000000_00000000, NB, 0, 1'b0);
    end_checks();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
